// File: rtl/hex_raster_pkg.sv
// Shared types for the hexagonal rasterizer render path: Q16.16 scalars,
// cube coordinates, batch scheduler states and a tag-width helper.
package hex_raster_pkg;

  typedef logic signed [31:0] q16_t;

  typedef struct packed {
    q16_t q;
    q16_t r;
    q16_t s;
  } hexcoord_q16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2
  } sched_state_t;

  localparam q16_t ROUND_HALF = 32'sh8000;

  // Index width for n requesters, never narrower than one bit.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_batch_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the lowest requesting index at or after the
// pointer (wrapping), returns it one-hot and as an index, and advances the
// pointer to winner+1 when the grant is consumed.
module rr_arbiter
  import hex_raster_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int PW   = tag_width(NREQ)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_winner,
  output logic            o_valid
);

  logic [PW-1:0] r_ptr;

  // Search from the pointer upward with wrap; first hit wins.
  always_comb begin
    logic [PW-1:0] w_idx;
    w_idx    = '0;
    o_grant  = '0;
    o_winner = '0;
    o_valid  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (!o_valid && i_req[w_idx]) begin
        o_valid         = 1'b1;
        o_winner        = w_idx;
        o_grant[w_idx]  = 1'b1;
      end
    end
  end

  // Pointer moves past the winner only on a consumed grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_advance && o_valid) begin
      r_ptr <= (o_winner == PW'(NREQ - 1)) ? '0 : o_winner + 1'b1;
    end
  end

endmodule

// File: rtl/hex_batch_scheduler.sv
// Batch scheduler feeding the BATCH-lane hexagonal rasterizer. Accepts one
// coordinate per cycle from NREQ requesters, packs lanes, fires on full,
// timeout or flush, and aligns mask/tags with the rasterizer result.
// Optional perf counters are built when HEX_SCHED_PERF_EN is defined.
//
//  state | meaning
//  IDLE  | no lanes loaded, granting
//  FILL  | partial batch, granting, timer running
//  ISSUE | one-cycle fire strobe, no grants, lanes clear at end
module hex_batch_scheduler
  import hex_raster_pkg::*;
#(
  parameter  int BATCH    = 10,
  parameter  int NREQ     = 4,
  parameter  int TIMEOUT  = 16,
  parameter  int RAST_LAT = 1,
  localparam int TW       = tag_width(NREQ)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  q16_t             req_q_f [NREQ],
  input  q16_t             req_r_f [NREQ],
  input  q16_t             req_s_f [NREQ],
  input  logic             flush,
  output logic             rast_valid_in,
  output q16_t             rast_q_f [BATCH],
  output q16_t             rast_r_f [BATCH],
  output q16_t             rast_s_f [BATCH],
  output logic             res_valid,
  output logic [BATCH-1:0] res_mask,
  output logic [TW-1:0]    res_tag [BATCH],
  output logic             busy
`ifdef HEX_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_batches,
  output logic [31:0]      perf_partial,
  output logic [31:0]      perf_stall
`endif
);

  localparam int CW  = $clog2(BATCH + 1);
  localparam int TMW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_FILL  = FILL;
  localparam logic [1:0] S_ISSUE = ISSUE;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_count;
  logic [TMW-1:0]   r_timer;
  hexcoord_q16_t    r_lane [BATCH];
  logic [TW-1:0]    r_tag  [BATCH];
  logic [BATCH-1:0] r_mask;

  logic             r_pv    [RAST_LAT];
  logic [BATCH-1:0] r_pmask [RAST_LAT];
  logic [TW-1:0]    r_ptag  [RAST_LAT][BATCH];

  logic             w_can_grant;
  logic [NREQ-1:0]  w_req;
  logic [NREQ-1:0]  w_grant;
  logic [TW-1:0]    w_winner;
  logic             w_accept;
  logic             w_issue;
  logic             w_last_lane;
  logic             w_timeout;

  assign w_can_grant = (r_state == S_IDLE) || (r_state == S_FILL);
  assign w_req       = req_valid & {NREQ{w_can_grant}};
  assign w_issue     = (r_state == S_ISSUE);
  assign w_last_lane = w_accept && (r_count == CW'(BATCH - 1));
  assign w_timeout   = (r_timer == TMW'(TIMEOUT - 1));

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (w_req),
    .i_advance (1'b1),
    .o_grant   (w_grant),
    .o_winner  (w_winner),
    .o_valid   (w_accept)
  );

  assign req_ready     = w_grant;
  assign rast_valid_in = w_issue;
  assign busy          = (r_state != S_IDLE);

  // Sequencing: an accept opens a batch; full, timeout or flush closes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= (BATCH == 1) ? S_ISSUE : S_FILL;
            r_timer <= '0;
          end
        end
        S_FILL: begin
          r_timer <= r_timer + 1'b1;
          if (w_last_lane || w_timeout || flush) r_state <= S_ISSUE;
        end
        S_ISSUE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane packing: accepted coordinate lands in lane[count]; ISSUE empties all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_mask  <= '0;
      for (int i = 0; i < BATCH; i++) begin
        r_lane[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (w_issue) begin
      r_count <= '0;
      r_mask  <= '0;
      for (int i = 0; i < BATCH; i++) begin
        r_lane[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (w_accept) begin
      r_count <= r_count + 1'b1;
      for (int i = 0; i < BATCH; i++) begin
        if (r_count == CW'(i)) begin
          r_lane[i] <= {req_q_f[w_winner], req_r_f[w_winner], req_s_f[w_winner]};
          r_tag[i]  <= w_winner;
          r_mask[i] <= 1'b1;
        end
      end
    end
  end

  // Lane data is only presented during the fire strobe.
  always_comb begin
    for (int i = 0; i < BATCH; i++) begin
      rast_q_f[i] = w_issue ? r_lane[i].q : '0;
      rast_r_f[i] = w_issue ? r_lane[i].r : '0;
      rast_s_f[i] = w_issue ? r_lane[i].s : '0;
    end
  end

  // Sideband pipeline matching rasterizer latency; zero outside valid slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < RAST_LAT; s++) begin
        r_pv[s]    <= 1'b0;
        r_pmask[s] <= '0;
        for (int l = 0; l < BATCH; l++) r_ptag[s][l] <= '0;
      end
    end else begin
      r_pv[0]    <= w_issue;
      r_pmask[0] <= w_issue ? r_mask : '0;
      for (int l = 0; l < BATCH; l++) r_ptag[0][l] <= w_issue ? r_tag[l] : '0;
      for (int s = 1; s < RAST_LAT; s++) begin
        r_pv[s]    <= r_pv[s-1];
        r_pmask[s] <= r_pmask[s-1];
        for (int l = 0; l < BATCH; l++) r_ptag[s][l] <= r_ptag[s-1][l];
      end
    end
  end

  assign res_valid = r_pv[RAST_LAT-1];
  assign res_mask  = r_pmask[RAST_LAT-1];
  assign res_tag   = r_ptag[RAST_LAT-1];

`ifdef HEX_SCHED_PERF_EN
  logic [31:0] r_perf_batches;
  logic [31:0] r_perf_partial;
  logic [31:0] r_perf_stall;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_batches <= '0;
      r_perf_partial <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_issue) r_perf_batches <= r_perf_batches + 32'd1;
      if (w_issue && (r_count != CW'(BATCH))) r_perf_partial <= r_perf_partial + 32'd1;
      if ((|req_valid) && !w_accept) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_batches = r_perf_batches;
  assign perf_partial = r_perf_partial;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_hex_batch_scheduler.sv
// Directed bench for hex_batch_scheduler: streaming, round-robin order,
// timeout, flush, asynchronous reset mid-flight and (with
// HEX_SCHED_PERF_EN) the perf counters.
module tb_hex_batch_scheduler;
  import hex_raster_pkg::*;

  localparam int BATCH = 10;
  localparam int NREQ  = 4;
  localparam int TW    = 2;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b1;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  q16_t             req_q_f [NREQ];
  q16_t             req_r_f [NREQ];
  q16_t             req_s_f [NREQ];
  logic             flush;
  logic             rast_valid_in;
  q16_t             rast_q_f [BATCH];
  q16_t             rast_r_f [BATCH];
  q16_t             rast_s_f [BATCH];
  logic             res_valid;
  logic [BATCH-1:0] res_mask;
  logic [TW-1:0]    res_tag [BATCH];
  logic             busy;
`ifdef HEX_SCHED_PERF_EN
  logic [31:0]      perf_batches;
  logic [31:0]      perf_partial;
  logic [31:0]      perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  hex_batch_scheduler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_q_f       (req_q_f),
    .req_r_f       (req_r_f),
    .req_s_f       (req_s_f),
    .flush         (flush),
    .rast_valid_in (rast_valid_in),
    .rast_q_f      (rast_q_f),
    .rast_r_f      (rast_r_f),
    .rast_s_f      (rast_s_f),
    .res_valid     (res_valid),
    .res_mask      (res_mask),
    .res_tag       (res_tag),
    .busy          (busy)
`ifdef HEX_SCHED_PERF_EN
    ,
    .perf_batches  (perf_batches),
    .perf_partial  (perf_partial),
    .perf_stall    (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_valid = '0;
    flush     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_q_f[i] = '0;
      req_r_f[i] = '0;
      req_s_f[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 reset_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (rast_valid_in !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rast_valid_in=%b res_valid=%b busy=%b, expected 0 0 0",
               rast_valid_in, res_valid, busy);
    end
    checks++;
    if (res_mask !== 10'h000 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mask_ready: res_mask=%h req_ready=%b, expected 000 0000", res_mask, req_ready);
    end
    for (int l = 0; l < BATCH; l++) begin
      checks++;
      if (rast_q_f[l] !== 32'sd0 || res_tag[l] !== 2'd0) begin
        errors++;
        $display("FAIL reset_lane%0d: q=%h tag=%0d, expected 0 0", l, rast_q_f[l], res_tag[l]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_stream();
    do_reset();
    for (int k = 0; k < BATCH; k++) begin
      @(negedge clk);
      req_valid  = 4'b0001;
      req_q_f[0] = q16_t'(k) <<< 16;
      req_r_f[0] = -(q16_t'(k) <<< 16);
      req_s_f[0] = '0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL single_ready k=%0d: got %b, expected 0001", k, req_ready);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (rast_valid_in !== 1'b1 || req_ready !== 4'b0000 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_issue: rast_valid_in=%b req_ready=%b res_valid=%b, expected 1 0000 0",
               rast_valid_in, req_ready, res_valid);
    end
    for (int l = 0; l < BATCH; l++) begin
      checks++;
      if (rast_q_f[l] !== (q16_t'(l) <<< 16) || rast_r_f[l] !== -(q16_t'(l) <<< 16) ||
          rast_s_f[l] !== 32'sd0) begin
        errors++;
        $display("FAIL single_lane%0d: q=%h r=%h s=%h, expected q=%h", l,
                 rast_q_f[l], rast_r_f[l], rast_s_f[l], q16_t'(l) <<< 16);
      end
    end
    req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_mask !== 10'h3FF || rast_valid_in !== 1'b0) begin
      errors++;
      $display("FAIL single_result: res_valid=%b res_mask=%h rast_valid_in=%b, expected 1 3ff 0",
               res_valid, res_mask, rast_valid_in);
    end
    for (int l = 0; l < BATCH; l++) begin
      checks++;
      if (res_tag[l] !== 2'd0) begin
        errors++;
        $display("FAIL single_tag%0d: got %0d, expected 0", l, res_tag[l]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || res_mask !== 10'h000) begin
      errors++;
      $display("FAIL single_after: res_valid=%b res_mask=%h, expected 0 000", res_valid, res_mask);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_q_f[i] = q16_t'(i + 1) <<< 16;
      req_r_f[i] = -(q16_t'(i + 1) <<< 16);
      req_s_f[i] = '0;
    end
    for (int k = 0; k < BATCH; k++) begin
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr_grant k=%0d: got %b, expected %b", k, req_ready, exp_rdy);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (rast_valid_in !== 1'b1 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rr_issue: rast_valid_in=%b req_ready=%b, expected 1 0000", rast_valid_in, req_ready);
    end
    for (int l = 0; l < BATCH; l++) begin
      checks++;
      if (rast_q_f[l] !== (q16_t'((l % 4) + 1) <<< 16)) begin
        errors++;
        $display("FAIL rr_lane%0d: got %h, expected %h", l, rast_q_f[l], q16_t'((l % 4) + 1) <<< 16);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_mask !== 10'h3FF || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rr_result: res_valid=%b res_mask=%h req_ready=%b, expected 1 3ff 0100",
               res_valid, res_mask, req_ready);
    end
    for (int l = 0; l < BATCH; l++) begin
      checks++;
      if (res_tag[l] !== 2'(l % 4)) begin
        errors++;
        $display("FAIL rr_tag%0d: got %0d, expected %0d", l, res_tag[l], l % 4);
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid  = 4'b0100;
      req_q_f[2] = q16_t'(k + 5) <<< 16;
      req_r_f[2] = -(q16_t'(k + 5) <<< 16);
      req_s_f[2] = '0;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL timeout_ready k=%0d: got %b, expected 0100", k, req_ready);
      end
    end
    @(negedge clk);
    req_valid = '0;
    repeat (13) @(negedge clk);
    #1;
    checks++;
    if (rast_valid_in !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: rast_valid_in=%b busy=%b, expected 0 1", rast_valid_in, busy);
    end
    @(negedge clk); #1;
    checks++;
    if (rast_valid_in !== 1'b1) begin
      errors++;
      $display("FAIL timeout_issue: rast_valid_in=%b, expected 1", rast_valid_in);
    end
    for (int l = 0; l < BATCH; l++) begin
      checks++;
      if (l < 3) begin
        if (rast_q_f[l] !== (q16_t'(l + 5) <<< 16) || rast_r_f[l] !== -(q16_t'(l + 5) <<< 16)) begin
          errors++;
          $display("FAIL timeout_lane%0d: q=%h r=%h, expected q=%h", l, rast_q_f[l], rast_r_f[l],
                   q16_t'(l + 5) <<< 16);
        end
      end else if (rast_q_f[l] !== 32'sd0 || rast_r_f[l] !== 32'sd0 || rast_s_f[l] !== 32'sd0) begin
        errors++;
        $display("FAIL timeout_lane%0d: q=%h r=%h s=%h, expected 0", l, rast_q_f[l], rast_r_f[l], rast_s_f[l]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_mask !== 10'h007) begin
      errors++;
      $display("FAIL timeout_result: res_valid=%b res_mask=%h, expected 1 007", res_valid, res_mask);
    end
    for (int l = 0; l < 3; l++) begin
      checks++;
      if (res_tag[l] !== 2'd2) begin
        errors++;
        $display("FAIL timeout_tag%0d: got %0d, expected 2", l, res_tag[l]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid  = 4'b1000;
      req_q_f[3] = (q16_t'(k) <<< 16) + ROUND_HALF;
      req_r_f[3] = '0;
      req_s_f[3] = -((q16_t'(k) <<< 16) + ROUND_HALF);
      flush      = (k == 4);
    end
    @(negedge clk);
    flush     = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if (rast_valid_in !== 1'b1 || rast_q_f[4] !== 32'sh0004_8000 || rast_s_f[4] !== -32'sh0004_8000 ||
        rast_q_f[5] !== 32'sd0) begin
      errors++;
      $display("FAIL flush_issue: rast_valid_in=%b lane4_q=%h lane4_s=%h lane5_q=%h, expected 1 00048000 fffb8000 0",
               rast_valid_in, rast_q_f[4], rast_s_f[4], rast_q_f[5]);
    end
    @(negedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_mask !== 10'h01F) begin
      errors++;
      $display("FAIL flush_result: res_valid=%b res_mask=%h, expected 1 01f", res_valid, res_mask);
    end
    for (int l = 0; l < 5; l++) begin
      checks++;
      if (res_tag[l] !== 2'd3) begin
        errors++;
        $display("FAIL flush_tag%0d: got %0d, expected 3", l, res_tag[l]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      flush = (c < 3);
      #1;
      checks++;
      if (rast_valid_in !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL flush_idle c=%0d: rast_valid_in=%b busy=%b, expected 0 0", c, rast_valid_in, busy);
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_valid  = 4'b0010;
      req_q_f[1] = q16_t'(k + 1) <<< 16;
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midfill_busy: got %b, expected 1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rast_valid_in !== 1'b0 || res_valid !== 1'b0 || res_mask !== 10'h000) begin
      errors++;
      $display("FAIL midfill_reset: busy=%b rast_valid_in=%b res_valid=%b res_mask=%h, expected 0 0 0 000",
               busy, rast_valid_in, res_valid, res_mask);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < BATCH; k++) begin
      @(negedge clk);
      req_valid  = 4'b0010;
      req_q_f[1] = q16_t'(k + 1) <<< 16;
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (rast_valid_in !== 1'b1) begin
      errors++;
      $display("FAIL midlat_issue: rast_valid_in=%b, expected 1", rast_valid_in);
    end
    @(negedge clk); #1;
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL midlat_valid: res_valid=%b, expected 1", res_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_mask !== 10'h000 || res_tag[0] !== 2'd0) begin
      errors++;
      $display("FAIL midlat_reset: res_valid=%b res_mask=%h tag0=%0d, expected 0 000 0",
               res_valid, res_mask, res_tag[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if (res_valid !== 1'b0 || rast_valid_in !== 1'b0) begin
        errors++;
        $display("FAIL midlat_stale c=%0d: res_valid=%b rast_valid_in=%b, expected 0 0", c, res_valid, rast_valid_in);
      end
    end
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midlat_ptr: req_ready=%b, expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

`ifdef HEX_SCHED_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int k = 0; k < BATCH; k++) begin
      @(negedge clk);
      req_valid = 4'b0001;
    end
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    flush     = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (perf_batches !== 32'd2 || perf_partial !== 32'd1 || perf_stall !== 32'd2) begin
      errors++;
      $display("FAIL perf_counts: batches=%0d partial=%0d stall=%0d, expected 2 1 2",
               perf_batches, perf_partial, perf_stall);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single_stream();
    test_round_robin();
    test_timeout();
    test_flush();
    test_reset_midflight();
`ifdef HEX_SCHED_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
